// File: rtl/day_letter_scanner_if.sv
// rtl/day_letter_scanner_if.sv - letter inputs and multiplexed display outputs of the day scanner
interface day_letter_scanner_if;
  logic [3:0] FirstLetter;
  logic [3:0] SecondLetter;
  logic [3:0] ThirdLetter;
  logic [3:0] FourthLetter;
  logic       setValue;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output FirstLetter, SecondLetter, ThirdLetter, FourthLetter, setValue,
    input  seg, an, frame_tick
  );

  modport slave (
    input  FirstLetter, SecondLetter, ThirdLetter, FourthLetter, setValue,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/day_letter_scanner.sv
// rtl/day_letter_scanner.sv - frame-snapshotted 4-digit letter display multiplexer with set-mode blink
module day_letter_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 resetTime,
  day_letter_scanner_if.slave  bus
);
  localparam int             SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam int             CW        = 9;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(2 * BLINK_FRAMES - 1);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(BLINK_FRAMES);

  logic [SW-1:0] r_slot;
  logic [1:0]    r_digit;
  logic [3:0]    r_shadow [4];
  logic [CW-1:0] r_cnt;
  logic          r_blank;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_ft;

  logic [SW-1:0] w_slot;
  logic [1:0]    w_digit;
  logic          w_wrap;
  logic [3:0]    w_shadow [4];
  logic [CW-1:0] w_cnt;
  logic          w_blank;
  logic [6:0]    w_seg;
  logic [3:0]    w_an;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd1:    s = 7'h77;
      4'd2:    s = 7'h5E;
      4'd3:    s = 7'h79;
      4'd4:    s = 7'h71;
      4'd5:    s = 7'h76;
      4'd6:    s = 7'h30;
      4'd7:    s = 7'h54;
      4'd8:    s = 7'h3F;
      4'd9:    s = 7'h73;
      4'd10:   s = 7'h50;
      4'd11:   s = 7'h6D;
      4'd12:   s = 7'h78;
      4'd13:   s = 7'h3E;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Outputs are derived from the next-state values so they describe the slot being entered.
  always_comb begin
    w_slot   = r_slot + 1'b1;
    w_digit  = r_digit;
    w_wrap   = 1'b0;
    w_shadow = r_shadow;
    w_cnt    = r_cnt;
    w_blank  = r_blank;
    w_seg    = 7'h00;
    w_an     = 4'b0000;

    if (r_slot == SLOT_LAST) begin
      w_slot  = '0;
      w_digit = r_digit + 2'd1;
      w_wrap  = (r_digit == 2'd3);
    end

    if (w_wrap) begin
      w_shadow[0] = bus.FirstLetter;
      w_shadow[1] = bus.SecondLetter;
      w_shadow[2] = bus.ThirdLetter;
      w_shadow[3] = bus.FourthLetter;
      w_cnt       = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      w_blank     = bus.setValue && (w_cnt >= CNT_HALF);
    end

    if ((w_slot != '0) && !w_blank) begin
      w_an  = 4'b1000 >> w_digit;
      w_seg = decode(w_shadow[w_digit]);
    end
  end

  always_ff @(posedge clk) begin
    if (resetTime) begin
      r_slot  <= '0;
      r_digit <= 2'd0;
      for (int i = 0; i < 4; i++) r_shadow[i] <= 4'd0;
      r_cnt   <= '0;
      r_blank <= 1'b0;
      r_seg   <= 7'h00;
      r_an    <= 4'b0000;
      r_ft    <= 1'b0;
    end else begin
      r_slot   <= w_slot;
      r_digit  <= w_digit;
      r_shadow <= w_shadow;
      r_cnt    <= w_cnt;
      r_blank  <= w_blank;
      r_seg    <= w_seg;
      r_an     <= w_an;
      r_ft     <= w_wrap;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_ft;
endmodule
